// File: rtl/enc_pipe_pkg.sv
// Shared constants, character classes and mod-26 helper for the shift pipeline.
// Used by encrypt_pipe_shift_multi and enc_lane_rotate.
package enc_pipe_pkg;

    localparam int ALPHA_N = 26;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_LOWER = 2'd2
    } char_class_t;

    // Operands up to 31 are accepted; the single subtract is exact when a+b < 52.
    function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ALPHA_N)) begin
            s = s - 6'(ALPHA_N);
        end
        return s[4:0];
    endfunction

endpackage

// File: rtl/enc_lane_rotate.sv
// Combinational single-lane Caesar rotation from a pre-classified character.
// Non-alphabetic lanes pass the raw character through.
module enc_lane_rotate
    import enc_pipe_pkg::*;
(
    input  logic        [7:0] ch,
    input  char_class_t       cls,
    input  logic        [4:0] off,
    input  logic        [4:0] shift,
    input  logic              encrypt,
    output logic        [7:0] ch_out,
    output logic              alpha
);

    logic [5:0] sum;
    logic [4:0] rot;

    always_comb begin
        // Decrypt adds 26-s so both directions share one conditional subtract.
        sum = {1'b0, off} + (encrypt ? {1'b0, shift} : (6'(ALPHA_N) - {1'b0, shift}));
        if (sum >= 6'(ALPHA_N)) begin
            sum = sum - 6'(ALPHA_N);
        end
        rot = sum[4:0];

        ch_out = ch;
        alpha  = 1'b0;
        case (cls)
            CLS_UPPER: begin
                ch_out = ASCII_UPPER_A + {3'b000, rot};
                alpha  = 1'b1;
            end
            CLS_LOWER: begin
                ch_out = ASCII_LOWER_A + {3'b000, rot};
                alpha  = 1'b1;
            end
            default: begin
                ch_out = ch;
                alpha  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/encrypt_pipe_shift_multi.sv
// Two-stage multi-lane Caesar shift pipeline with rotor key schedule and valid/ready flow.
// Build option ENC_PIPE_LANE_STAGGER_EN: lane i uses (cur_shift + i) mod 26.
module encrypt_pipe_shift_multi
    import enc_pipe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [4:0]           shift_base,
    input  logic [4:0]           step_amt,
    input  logic [CNT_W-1:0]     rot_freq,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_alpha_mask
);

    // Handshake: a beat transfers on any cycle where valid && ready; both
    // stages advance together whenever the output register is empty or drained.
    logic adv;
    logic accept;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    logic [4:0]       cur_shift;
    logic [4:0]       step;
    logic [CNT_W-1:0] freq;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] freq_m1;

    assign freq_m1 = freq - {{(CNT_W-1){1'b0}}, 1'b1};

    char_class_t cls_d   [LANES];
    logic [4:0]  off_d   [LANES];
    logic [4:0]  shift_d [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [7:0] c;
            c = in_data[8*i +: 8];
            cls_d[i] = CLS_OTHER;
            off_d[i] = 5'd0;
            if (c >= ASCII_UPPER_A && c <= ASCII_UPPER_A + 8'd25) begin
                cls_d[i] = CLS_UPPER;
                off_d[i] = 5'(c - ASCII_UPPER_A);
            end else if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_A + 8'd25) begin
                cls_d[i] = CLS_LOWER;
                off_d[i] = 5'(c - ASCII_LOWER_A);
            end
`ifdef ENC_PIPE_LANE_STAGGER_EN
            shift_d[i] = mod26_add(cur_shift, 5'(i));
`else
            shift_d[i] = cur_shift;
`endif
        end
    end

    // Key schedule; cfg_load takes priority over a coincident rotor step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_shift <= 5'd0;
            step      <= 5'd0;
            freq      <= '0;
            beat_cnt  <= '0;
        end else if (cfg_load) begin
            cur_shift <= mod26_add(shift_base, 5'd0);
            step      <= mod26_add(step_amt, 5'd0);
            freq      <= rot_freq;
            beat_cnt  <= '0;
        end else if (accept && freq != '0) begin
            if (beat_cnt == freq_m1) begin
                beat_cnt  <= '0;
                cur_shift <= mod26_add(cur_shift, step);
            end else begin
                beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    logic               s1_valid;
    logic               s1_mode;
    logic [8*LANES-1:0] s1_char;
    char_class_t        s1_cls   [LANES];
    logic [4:0]         s1_off   [LANES];
    logic [4:0]         s1_shift [LANES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_char  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_cls[i]   <= CLS_OTHER;
                s1_off[i]   <= 5'd0;
                s1_shift[i] <= 5'd0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_char <= in_data;
                for (int i = 0; i < LANES; i++) begin
                    s1_cls[i]   <= cls_d[i];
                    s1_off[i]   <= off_d[i];
                    s1_shift[i] <= shift_d[i];
                end
            end
        end
    end

    logic [7:0] rot_char  [LANES];
    logic       rot_alpha [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        enc_lane_rotate u_rot (
            .ch      (s1_char[8*g +: 8]),
            .cls     (s1_cls[g]),
            .off     (s1_off[g]),
            .shift   (s1_shift[g]),
            .encrypt (s1_mode),
            .ch_out  (rot_char[g]),
            .alpha   (rot_alpha[g])
        );
    end

    logic [8*LANES-1:0] rot_data;
    logic [LANES-1:0]   rot_mask;

    always_comb begin
        rot_data = '0;
        rot_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            rot_data[8*i +: 8] = rot_char[i];
            rot_mask[i]        = rot_alpha[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_alpha_mask <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data       <= rot_data;
                out_alpha_mask <= rot_mask;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_shift_multi.sv
// Directed self-checking bench for encrypt_pipe_shift_multi (LANES=4).
// Under ENC_PIPE_LANE_STAGGER_EN only the staggered-key vector runs after reset checks.
module tb_encrypt_pipe_shift_multi;

    localparam int LANES = 4;
    localparam int CNT_W = 3;
    localparam int EW    = 8*LANES + LANES;

    logic                 clk;
    logic                 rst;
    logic                 cfg_load;
    logic [4:0]           shift_base;
    logic [4:0]           step_amt;
    logic [CNT_W-1:0]     rot_freq;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [LANES-1:0]     out_alpha_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    encrypt_pipe_shift_multi #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .shift_base     (shift_base),
        .step_amt       (step_amt),
        .rot_freq       (rot_freq),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_mode        (in_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_alpha_mask (out_alpha_mask)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // String literal "ABCD" -> lane0 = 'A'.
    function automatic logic [31:0] lanes(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

    // scoreboard: every delivered beat must match the head of exp_q
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {28'd0, out_alpha_mask, out_data}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_beat", {28'd0, out_alpha_mask, out_data}, {28'd0, mon_exp});
            end
        end
    end

    // driver tasks
    task automatic cfg(input logic [4:0] base, input logic [4:0] stp, input logic [CNT_W-1:0] frq);
        shift_base = base;
        step_amt   = stp;
        rot_freq   = frq;
        cfg_load   = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic m, input logic [31:0] ed,
                        input logic [3:0] em, input logic load);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        cfg_load = load;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({em, ed});
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        cfg_load   = 1'b0;
        shift_base = 5'd0;
        step_amt   = 5'd0;
        rot_freq   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mode    = 1'b1;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mask", 64'(out_alpha_mask), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

`ifdef ENC_PIPE_LANE_STAGGER_EN
        cfg(5'd0, 5'd0, 3'd0);
        send(lanes("AAAA"), 1'b1, lanes("ABCD"), 4'hF, 1'b0);
        send(lanes("BCDE"), 1'b0, lanes("BBBB"), 4'hF, 1'b0);
        wait_drain("stagger_drain");
`else
        // 1: basic encrypt and two-cycle latency
        cfg(5'd1, 5'd0, 3'd0);
        send(lanes("ABYZ"), 1'b1, lanes("BCZA"), 4'hF, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        wait_drain("t1_drain");

        // 2: lowercase wrap, non-alpha passthrough, base reduction
        cfg(5'd3, 5'd0, 3'd0);
        send(lanes("az0@"), 1'b1, lanes("dc0@"), 4'b0011, 1'b0);
        cfg(5'd30, 5'd0, 3'd0);
        send(lanes("AAAA"), 1'b1, lanes("EEEE"), 4'hF, 1'b0);
        wait_drain("t2_drain");

        // 3: decrypt and per-beat mode on back-to-back beats
        cfg(5'd1, 5'd0, 3'd0);
        send(lanes("BCZA"), 1'b0, lanes("ABYZ"), 4'hF, 1'b0);
        send(lanes("abcd"), 1'b1, lanes("bcde"), 4'hF, 1'b0);
        send(lanes("abcd"), 1'b0, lanes("zabc"), 4'hF, 1'b0);
        send(lanes("Hi!z"), 1'b1, lanes("Ij!a"), 4'b1011, 1'b0);
        wait_drain("t3_drain");

        // 4: rotor every two beats, then cfg_load on a live beat
        cfg(5'd0, 5'd2, 3'd2);
        send(lanes("AAAA"), 1'b1, lanes("AAAA"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("AAAA"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("CCCC"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("CCCC"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("EEEE"), 4'hF, 1'b0);
        wait_drain("t4a_drain");
        cfg(5'd0, 5'd2, 3'd2);
        send(lanes("AAAA"), 1'b1, lanes("AAAA"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("AAAA"), 4'hF, 1'b0);
        shift_base = 5'd10;
        step_amt   = 5'd28;
        rot_freq   = 3'd2;
        send(lanes("AAAA"), 1'b1, lanes("CCCC"), 4'hF, 1'b1);
        send(lanes("AAAA"), 1'b1, lanes("KKKK"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("KKKK"), 4'hF, 1'b0);
        send(lanes("AAAA"), 1'b1, lanes("MMMM"), 4'hF, 1'b0);
        wait_drain("t4b_drain");

        // 5: backpressure with a rotor stepping on every accept
        cfg(5'd0, 5'd1, 3'd1);
        out_ready = 1'b0;
        fork
            begin
                send(lanes("AAAA"), 1'b1, lanes("AAAA"), 4'hF, 1'b0);
                send(lanes("AAAA"), 1'b1, lanes("BBBB"), 4'hF, 1'b0);
                send(lanes("AAAA"), 1'b1, lanes("CCCC"), 4'hF, 1'b0);
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_stable", 64'(out_data), 64'(lanes("AAAA")));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset mid-stream
        @(posedge clk);
        #1;
        cfg(5'd5, 5'd1, 3'd3);
        out_ready = 1'b0;
        send(lanes("ABCD"), 1'b1, lanes("FGHI"), 4'hF, 1'b0);
        send(lanes("ABCD"), 1'b1, lanes("FGHI"), 4'hF, 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_shift", 64'(dut.cur_shift), 64'd0);
        check("async_rst_cnt", 64'(dut.beat_cnt), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(lanes("ABCD"), 1'b1, lanes("ABCD"), 4'hF, 1'b0);
        send(lanes("wxyz"), 1'b0, lanes("wxyz"), 4'hF, 1'b0);
        wait_drain("t6_drain");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/encrypt_pipe_shift_multi.md
Name: encrypt_pipe_shift_multi

Overview:
Parametrised successor to the single-character shift pipeline: classifies and Caesar-rotates LANES ASCII characters per beat.
Provides a valid/ready handshake and a rotor-style key schedule: the shift amount advances by a programmed step every rot_freq accepted beats.
Sits between the input formatter and the XOR stage of the encrypt/decrypt datapath.
Encrypt and decrypt are selected per beat.

Parameters:
LANES, 4, characters per beat (1..16); data width = 8*LANES.
CNT_W, 3, width of the rotation-frequency field and the beat counter.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low.
cfg_load  in  1  capture shift_base, step_amt and rot_freq this cycle.
shift_base  in  5  initial shift; values 26..31 reduced by 26 on capture.
step_amt  in  5  rotor step; same reduction as shift_base.
rot_freq  in  CNT_W  accepted beats per rotor step; 0 = rotor off.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_data  in  8*LANES  lane i = bits [8i+7:8i].
in_mode  in  1  1 = encrypt, 0 = decrypt; travels with the beat.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream ready.
out_data  out  8*LANES  rotated characters.
out_alpha_mask  out  LANES  bit i = lane i was alphabetic.

Behaviour:
- Reset: out_valid=0, out_data=0, out_alpha_mask=0, all stage-1 registers 0, cur_shift=0, step=0, freq=0, beat_cnt=0.
- Reset is asynchronous; asserting it mid-stream drops all in-flight beats with no flush.
- Pipeline: two register stages sharing one enable, adv = !out_valid || out_ready. in_ready = adv (combinational; 1 after reset).
- Latency: an accepted beat appears on out_* 2 cycles later when out_ready is held high.
- Stall: while out_valid && !out_ready, all stage registers hold and out_data stays stable. No beat is lost or duplicated; bubbles are allowed in stage 1.
- Stage 1 registers, per lane:
  - class: UPPER for 8'h41..8'h5A, LOWER for 8'h61..8'h7A, else OTHER.
  - char offset (c - base).
  - mode, and the lane shift s_i (cur_shift at accept time).
- Stage 2 rotation:
  - encrypt: (off + s) mod 26 + base.
  - decrypt: (off + 26 - s) mod 26 + base.
  - OTHER lanes pass through unchanged, mask bit 0.
  - All arithmetic is 6-bit with a single conditional subtract of 26; no divider.
- Rotor:
  - beat_cnt increments on each accepted beat.
  - When freq != 0 and an accept happens with beat_cnt == freq-1: beat_cnt <= 0 and cur_shift <= (cur_shift + step) mod 26.
  - When freq == 0, cur_shift and beat_cnt hold.
- cfg_load:
  - Loads cur_shift=shift_base mod 26, step, freq; clears beat_cnt.
  - If cfg_load coincides with an accept, that beat uses the old cur_shift and cfg_load wins over the rotor step.
  - Beats already in flight are unaffected.
- Wrap cases: 'Z'+1 = 'A', 'a'-1 = 'z', shift 0 is identity.

Optional Feature:
Macro ENC_PIPE_LANE_STAGGER_EN.
- Defined: lane i uses s_i = (cur_shift + i) mod 26 (progressive key across lanes).
- Undefined: every lane uses cur_shift.
- The rotor and handshake are identical in both builds.

Decomposition:
- Package enc_pipe_pkg holds:
  - constants ALPHA_N=26, ASCII_UPPER_A=8'h41, ASCII_LOWER_A=8'h61;
  - typedef enum logic [1:0] char_class_t {CLS_OTHER, CLS_UPPER, CLS_LOWER};
  - function mod26_add(a,b) on 5-bit operands.
- Sub-module enc_lane_rotate: combinational class/offset/shift/mode in, rotated char out; instantiated LANES times in stage 2.

Test Plan:
1. LANES=4, cfg_load with shift_base=1, rot_freq=0; encrypt "ABYZ" (lane0='A') -> "BCZA" two cycles later, mask 4'hF.
2. shift_base=3, encrypt "az0@" -> "dc0@", mask 4'b0011; then shift_base=30 on "AAAA" -> "EEEE".
3. Decrypt, shift_base=1, "BCZA" -> "ABYZ"; alternate in_mode on back-to-back beats -> each beat rotated per its own mode.
4. shift_base=0, step=2, rot_freq=2, five "AAAA" beats -> "AAAA","AAAA","CCCC","CCCC","EEEE".
   - Repeat with cfg_load on beat 2 -> beat 2 still "CCCC", later beats restart from the new base.
5. Backpressure: 3 beats issued, out_ready=0 for 5 cycles -> in_ready=0, out_data stable. Rotor advances only on accepts; all 3 beats delivered once, in order.
6. rst low for 1 cycle while out_valid=1 and mid-stream -> out_valid=0 immediately, cur_shift=0, beat_cnt=0; after release "ABCD" passes unchanged until cfg_load.
   - ENC_PIPE_LANE_STAGGER_EN build with shift_base=0 on "AAAA" -> "ABCD".
